// File: rtl/dcsr_bank.sv
// Circular shift-register bank streaming operand bit columns to the multiplier.
// Optional DCSR_MSB_FIRST_EN: rotate left and stream MSB-first.
module dcsr_bank #(
    parameter int N  = 4,
    parameter int CH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [CH*N-1:0] ddata,
    input  logic            start,
    input  logic            coef_ready,
    output logic [CH-1:0]   dcoef,
    output logic            coef_valid,
    output logic            busy,
    output logic            done
);

    localparam int CW = ($clog2(N) > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CH-1:0][N-1:0]    sr_q, sr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    for (int i = 0; i < CH; i++) begin
                        sr_d[i] = ddata[N*i +: N];
                    end
                end
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (coef_ready) begin
                    // N rotations bring every channel back to its loaded value
                    for (int i = 0; i < CH; i++) begin
`ifdef DCSR_MSB_FIRST_EN
                        sr_d[i] = {sr_q[i][N-2:0], sr_q[i][N-1]};
`else
                        sr_d[i] = {sr_q[i][0], sr_q[i][N-1:1]};
`endif
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N-1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
`ifdef DCSR_MSB_FIRST_EN
            dcoef[i] = sr_q[i][N-1];
`else
            dcoef[i] = sr_q[i][0];
`endif
        end
    end

    assign coef_valid = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = done_q;

endmodule
